mem_port_arbiter: RTL

Shares one unified memory port between the instruction-fetch requester (IF) and the load/store requester (MEM) for the multicycle core variant. Each access is a single-beat transaction with a req/done handshake. The arbiter latches the request, drives the memory port until `mem_ack_i`, and returns read data plus a one-cycle done pulse. It sits between IF/MEM and the top-level memory pins, which replace the separate inst/data ports.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_arb_pick.sv | 25 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between the IF and MEM requesters.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_PRIORITY = 1
) (
  input  logic inst_req,
  input  logic data_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = inst_req | data_req;
    grant_owner = OWN_INST;
    if (inst_req && data_req) begin
      // Round-robin hands the port to whoever did not win last time.
      grant_owner = (DATA_PRIORITY != 0) ? OWN_DATA : ~last_grant;
    end else if (data_req) begin
      grant_owner = OWN_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-beat memory port between instruction fetch and load/store.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_PRIORITY  = 1,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_req_i,
  input  logic [XLEN-1:0] inst_addr_i,
  output logic            inst_done_o,
  output logic [XLEN-1:0] inst_rdata_o,
  input  logic            data_req_i,
  input  logic            data_we_i,
  input  logic [XLEN-1:0] data_addr_i,
  input  logic [XLEN-1:0] data_wdata_i,
  output logic            data_done_o,
  output logic [XLEN-1:0] data_rdata_o,
  output logic            mem_ce_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_ack_i,
  output logic            timeout_o
);

  arb_state_e      state, state_next;
  logic            owner;
  logic            last_grant;
  logic            lat_we;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;
  logic [TO_W-1:0] cnt;
  logic [XLEN-1:0] inst_rdata_q;
  logic [XLEN-1:0] data_rdata_q;
  logic            timeout_q;
  logic            grant_valid;
  logic            grant_owner;
  logic            to_hit;

  mem_arb_pick #(
    .DATA_PRIORITY(DATA_PRIORITY)
  ) u_pick (
    .inst_req   (inst_req_i),
    .data_req   (data_req_i),
    .last_grant (last_grant),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timeout
      assign to_hit = (cnt == TO_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign to_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ACCESS;
      ACCESS:  if (mem_ack_i || to_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner        <= OWN_INST;
      last_grant   <= OWN_INST;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      cnt          <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner      <= grant_owner;
            last_grant <= grant_owner;
            lat_we     <= (grant_owner == OWN_DATA) && data_we_i;
            lat_addr   <= (grant_owner == OWN_DATA) ? data_addr_i : inst_addr_i;
            lat_wdata  <= data_wdata_i;
            cnt        <= '0;
          end
        end
        ACCESS: begin
          // An ack in the final allowed cycle still completes normally.
          if (mem_ack_i) begin
            if (!lat_we) begin
              if (owner == OWN_INST) inst_rdata_q <= mem_rdata_i;
              else                   data_rdata_q <= mem_rdata_i;
            end
          end else if (to_hit) begin
            timeout_q <= 1'b1;
            if (owner == OWN_INST) inst_rdata_q <= '0;
            else                   data_rdata_q <= '0;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_ce_o     = (state == ACCESS);
  assign mem_we_o     = mem_ce_o & lat_we;
  assign mem_addr_o   = mem_ce_o ? lat_addr  : '0;
  assign mem_wdata_o  = mem_ce_o ? lat_wdata : '0;
  assign inst_done_o  = (state == RESP) && (owner == OWN_INST);
  assign data_done_o  = (state == RESP) && (owner == OWN_DATA);
  assign inst_rdata_o = inst_rdata_q;
  assign data_rdata_o = data_rdata_q;
  assign timeout_o    = timeout_q;

endmodule
